multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: OPC_W, 4, instruction opcode width.
REQ-002 Parameter: ALUOP_W, 3, ALU operation select width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  OPC_W  opcode field of the external instruction register.
REQ-006 zero  input  1  ALU zero flag, valid in the EXEC cycle.
REQ-007 mem_ack  input  1  memory handshake acknowledge.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  memory write qualifier, valid only while mem_req=1.
REQ-010 ir_load  output  1  one-cycle pulse that loads the instruction register.
REQ-011 pc_inc  output  1  one-cycle pulse that increments the PC.
REQ-012 pc_load  output  1  one-cycle pulse that loads the branch target into the PC.
REQ-013 alu_op  output  ALUOP_W  ALU result-mux select.
REQ-014 reg_we  output  1  one-cycle register-file write enable.
REQ-015 halted  output  1  core stopped.
REQ-016 illegal  output  1  sticky flag set when an undefined opcode is decoded.

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT, and the state register SHALL be the only sequential path between them.
REQ-018 The opcode map SHALL be: 0000 mov, 0001 not, 0010 add, 0011 sub, 0100 or, 0101 and, 0110 xor, 0111 ld, 1000 st, 1001 beq, 1111 halt; every other opcode is illegal.
REQ-019 The alu_op encoding SHALL be: mov 000, not 001, add 010, sub 011, or 100, and 101, xor 110; code 111 SHALL never be driven.
REQ-020 In FETCH, mem_req SHALL be 1 and mem_we SHALL be 0; in the cycle mem_ack=1, ir_load and pc_inc SHALL each pulse for one cycle and the next state SHALL be DECODE.
REQ-021 An ack SHALL be accepted in the first cycle of the request; while mem_ack=0 the FSM SHALL hold its state and keep mem_req asserted.
REQ-022 DECODE SHALL last exactly one cycle and SHALL register opcode into an internal op register; this register, not the opcode port, SHALL drive all decisions until the next DECODE.
REQ-023 alu_op SHALL be registered and updated only at the DECODE-to-EXEC edge: ALU opcodes map per REQ-019, ld/st map to add, beq maps to sub, and halt/illegal map to 000; alu_op SHALL hold that value through WB/MEM.
REQ-024 EXEC transitions: ALU opcode to WB; ld/st to MEM; beq to FETCH, with pc_load pulsed in EXEC if zero=1; halt to HALT; illegal to HALT with illegal set.
REQ-025 In MEM, mem_req SHALL be 1 and mem_we SHALL be 1 for st only; on mem_ack, ld SHALL go to WB and st SHALL go to FETCH.
REQ-026 WB SHALL pulse reg_we for exactly one cycle and then go to FETCH.
REQ-027 Minimum latency with zero-wait memory SHALL be: ALU op 4 cycles, beq 3, ld 5, st 4.
REQ-028 HALT SHALL be absorbing: halted=1, no mem_req, and no pulses until reset.
REQ-029 All outputs except alu_op, halted and illegal SHALL be decoded from state plus inputs, and SHALL be glitch-free with respect to clk.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state FETCH, op register 0, alu_op 000, and illegal/halted 0, including in the middle of a MEM handshake.
REQ-031 While rst_n=0, mem_req, mem_we, ir_load, pc_inc, pc_load and reg_we SHALL be 0; mem_req SHALL rise in the first cycle after release.

Structure
REQ-032 The opcode constants, alu_op constants and state encoding SHALL reside in a shared package, which is also used by the datapath result mux.
REQ-033 The opcode-to-alu_op mapping SHALL be one combinational sub-module, alu_op_decode, and the FSM SHALL remain in multicycle_ctrl.

Verification
REQ-034 Reset release, add (0010), mem_ack tied to 1 -> ir_load/pc_inc in cycle 1, alu_op=010 from cycle 3, reg_we in cycle 4, mem_req again in cycle 5.
REQ-035 ld (0111), with MEM ack delayed 3 cycles -> mem_req=1 and mem_we=0 held 4 cycles, alu_op=010, a single reg_we pulse after the ack.
REQ-036 beq (1001) twice, once with zero=1 and once with zero=0 -> alu_op=011 both times; pc_load pulses once only in the zero=1 case; no reg_we.
REQ-037 Opcode 1010 -> illegal=1, halted=1, no further mem_req for 20 cycles; rst_n pulse clears both flags.
REQ-038 st (1000), with rst_n asserted mid-MEM while mem_ack=0 -> mem_req/mem_we drop asynchronously to 0 and the FSM restarts in FETCH after release.
REQ-039 Sweep opcodes 0000-0110 -> alu_op equals 000-110 respectively, and 111 never appears.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared opcode, alu_op and state definitions for the multicycle core
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OPC_MOV  = 4'b0000;
    localparam logic [3:0] OPC_NOT  = 4'b0001;
    localparam logic [3:0] OPC_ADD  = 4'b0010;
    localparam logic [3:0] OPC_SUB  = 4'b0011;
    localparam logic [3:0] OPC_OR   = 4'b0100;
    localparam logic [3:0] OPC_AND  = 4'b0101;
    localparam logic [3:0] OPC_XOR  = 4'b0110;
    localparam logic [3:0] OPC_LD   = 4'b0111;
    localparam logic [3:0] OPC_ST   = 4'b1000;
    localparam logic [3:0] OPC_BEQ  = 4'b1001;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_HALT = 3'd4,
        CLS_ILL  = 3'd5
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] opc);
        case (opc)
            OPC_MOV, OPC_NOT, OPC_ADD, OPC_SUB,
            OPC_OR, OPC_AND, OPC_XOR: op_class = CLS_ALU;
            OPC_LD:                   op_class = CLS_LD;
            OPC_ST:                   op_class = CLS_ST;
            OPC_BEQ:                  op_class = CLS_BEQ;
            OPC_HALT:                 op_class = CLS_HALT;
            default:                  op_class = CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller-to-datapath/memory signal bundle
interface multicycle_ctrl_if #(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3
);
    logic [OPC_W-1:0]   opcode;
    logic               zero;
    logic               mem_ack;
    logic               mem_req;
    logic               mem_we;
    logic               ir_load;
    logic               pc_inc;
    logic               pc_load;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_we;
    logic               halted;
    logic               illegal;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, ir_load, pc_inc, pc_load, alu_op, reg_we, halted, illegal
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, ir_load, pc_inc, pc_load, alu_op, reg_we, halted, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// rtl/multicycle_ctrl_alu_op_decode.sv - combinational opcode to ALU result-select mapping
module alu_op_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3
) (
    input  logic [OPC_W-1:0]   opcode,
    output logic [ALUOP_W-1:0] alu_op
);

    // Memory ops compute an address with add, beq compares with sub; halt and illegal park on mov.
    always_comb begin
        alu_op = ALU_MOV;
        case (opcode)
            OPC_MOV:        alu_op = ALU_MOV;
            OPC_NOT:        alu_op = ALU_NOT;
            OPC_ADD:        alu_op = ALU_ADD;
            OPC_SUB:        alu_op = ALU_SUB;
            OPC_OR:         alu_op = ALU_OR;
            OPC_AND:        alu_op = ALU_AND;
            OPC_XOR:        alu_op = ALU_XOR;
            OPC_LD, OPC_ST: alu_op = ALU_ADD;
            OPC_BEQ:        alu_op = ALU_SUB;
            default:        alu_op = ALU_MOV;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB/HALT control FSM of a multicycle core
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int ALUOP_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               halted_q, illegal_q;
    op_class_e          cls;

    logic mem_req_c, mem_we_c, ir_load_c, pc_inc_c, pc_load_c, reg_we_c;

    alu_op_decode #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) u_alu_op_decode (
        .opcode (bus.opcode),
        .alu_op (dec_alu_op)
    );

    // Only the latched opcode steers EXEC/MEM so the IR may change after DECODE.
    assign cls = op_class(op_q);

    always_comb begin
        state_d   = state_q;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        ir_load_c = 1'b0;
        pc_inc_c  = 1'b0;
        pc_load_c = 1'b0;
        reg_we_c  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    ir_load_c = 1'b1;
                    pc_inc_c  = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    CLS_ALU:         state_d = ST_WB;
                    CLS_LD, CLS_ST:  state_d = ST_MEM;
                    CLS_BEQ: begin
                        pc_load_c = bus.zero;
                        state_d   = ST_FETCH;
                    end
                    default:         state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (cls == CLS_ST);
                if (bus.mem_ack) begin
                    state_d = (cls == CLS_LD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            alu_op_q  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q     <= bus.opcode;
                alu_op_q <= dec_alu_op;
            end
            if (state_q == ST_EXEC && state_d == ST_HALT) begin
                halted_q <= 1'b1;
                if (cls == CLS_ILL) illegal_q <= 1'b1;
            end
        end
    end

    // Reset leaves the state in FETCH, so strobes are qualified by rst_n to stay quiet during reset.
    assign bus.mem_req = mem_req_c & rst_n;
    assign bus.mem_we  = mem_we_c  & rst_n;
    assign bus.ir_load = ir_load_c & rst_n;
    assign bus.pc_inc  = pc_inc_c  & rst_n;
    assign bus.pc_load = pc_load_c & rst_n;
    assign bus.reg_we  = reg_we_c  & rst_n;
    assign bus.alu_op  = alu_op_q;
    assign bus.halted  = halted_q;
    assign bus.illegal = illegal_q;

endmodule
